regfile_responder: RTL and testbench

Request/response front end with integrated 32 x 32-bit register storage. It serves a sequential initiator through a valid/ready request port and returns read data through a buffered valid/ready response port. It replaces direct combinational read-port access wherever the initiator cannot guarantee the same-cycle read timing. Register 0 always reads zero.

---
 rtl/regfile_responder.sv | 142 ++++++++++++++
 tb/tb_regfile_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_responder.sv
// Request/response register file: 32 x 32-bit storage (reg 0 reads zero) behind a buffered response FIFO.
// Optional write acknowledges are enabled with `define REGFILE_WRITE_ACK_EN.
module regfile_responder #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_reg,
  output logic [31:0] resp_data,
  output logic        resp_is_write
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

  logic [31:0]   regFile_r [1:31];
  logic [4:0]    fifoReg_r  [DEPTH];
  logic [31:0]   fifoData_r [DEPTH];
  logic          fifoWr_r   [DEPTH];
  logic [PW-1:0] wrPtr_r;
  logic [PW-1:0] rdPtr_r;
  logic [CW-1:0] count_r;

  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          pushWr_s;
  logic [31:0]   pushData_s;
  logic [31:0]   readVal_s;
  logic [PW-1:0] nextRd_s;
  logic [CW-1:0] nextCount_s;
  logic          headValid_s;
  logic [4:0]    headReg_s;
  logic [31:0]   headData_s;
  logic          headWr_s;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    if (p == LAST_PTR_C) begin
      incPtr = {PW{1'b0}};
    end else begin
      incPtr = p + PW'(1);
    end
  endfunction

  // Readiness depends only on occupancy and reset, never on request/response inputs.
  assign req_ready = !ctrl_reset && (count_r != DEPTH_C);

  // Request decode, FIFO bookkeeping and next head-of-queue selection.
  always_comb begin
    readVal_s   = 32'h0;
    if (req_reg != 5'd0) begin
      readVal_s = regFile_r[req_reg];
    end else begin
      readVal_s = 32'h0;
    end
    accept_s    = req_valid && req_ready;
`ifdef REGFILE_WRITE_ACK_EN
    push_s      = accept_s;
    pushWr_s    = req_write;
    if (req_write) begin
      pushData_s = (req_reg == 5'd0) ? 32'h0 : req_data;
    end else begin
      pushData_s = readVal_s;
    end
`else
    push_s      = accept_s && !req_write;
    pushWr_s    = 1'b0;
    pushData_s  = readVal_s;
`endif
    pop_s       = resp_valid && resp_ready;
    nextRd_s    = pop_s ? incPtr(rdPtr_r) : rdPtr_r;
    case ({push_s, pop_s})
      2'b10:   nextCount_s = count_r + CW'(1);
      2'b01:   nextCount_s = count_r - CW'(1);
      default: nextCount_s = count_r;
    endcase
    // The output flops mirror the entry that will be at the head after this edge.
    if (nextCount_s == CW'(0)) begin
      headValid_s = 1'b0;
      headReg_s   = 5'd0;
      headData_s  = 32'h0;
      headWr_s    = 1'b0;
    end else if (push_s && (nextRd_s == wrPtr_r)) begin
      headValid_s = 1'b1;
      headReg_s   = req_reg;
      headData_s  = pushData_s;
      headWr_s    = pushWr_s;
    end else begin
      headValid_s = 1'b1;
      headReg_s   = fifoReg_r[nextRd_s];
      headData_s  = fifoData_r[nextRd_s];
      headWr_s    = fifoWr_r[nextRd_s];
    end
  end

  // Register storage, FIFO state and registered response outputs.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        regFile_r[i] <= 32'h0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifoReg_r[i]  <= 5'd0;
        fifoData_r[i] <= 32'h0;
        fifoWr_r[i]   <= 1'b0;
      end
      wrPtr_r       <= {PW{1'b0}};
      rdPtr_r       <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      resp_valid    <= 1'b0;
      resp_reg      <= 5'd0;
      resp_data     <= 32'h0;
      resp_is_write <= 1'b0;
    end else begin
      if (accept_s && req_write && (req_reg != 5'd0)) begin
        regFile_r[req_reg] <= req_data;
      end
      if (push_s) begin
        fifoReg_r[wrPtr_r]  <= req_reg;
        fifoData_r[wrPtr_r] <= pushData_s;
        fifoWr_r[wrPtr_r]   <= pushWr_s;
        wrPtr_r             <= incPtr(wrPtr_r);
      end
      rdPtr_r       <= nextRd_s;
      count_r       <= nextCount_s;
      resp_valid    <= headValid_s;
      resp_reg      <= headReg_s;
      resp_data     <= headData_s;
      resp_is_write <= headWr_s;
    end
  end

endmodule

// File: tb/tb_regfile_responder.sv
// Scoreboard bench for regfile_responder: expected responses are queued at request
// acceptance and compared when the DUT pops its head entry.
module tb_regfile_responder;

  typedef struct packed {
    logic        w;
    logic [4:0]  r;
    logic [31:0] d;
  } resp_t;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_reg = 5'd0;
  logic [31:0] req_data = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [4:0]  resp_reg;
  logic [31:0] resp_data;
  logic        resp_is_write;

  resp_t       expQ[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  regfile_responder #(.DEPTH(2)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_reg(resp_reg),
    .resp_data(resp_data), .resp_is_write(resp_is_write)
  );

  always #5 clock = ~clock;

  // Scoreboard: a pop happens at the next rising edge, so compare the head at the falling edge.
  always @(negedge clock) begin : monitor
    resp_t e;
    if (!ctrl_reset && resp_valid && resp_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got w=%0b reg=%0d data=%h, required no response",
                 resp_is_write, resp_reg, resp_data);
      end else begin
        e = expQ.pop_front();
        if ({resp_is_write, resp_reg, resp_data} !== e) begin
          errors++;
          $display("FAIL resp_order: got w=%0b reg=%0d data=%h, required w=%0b reg=%0d data=%h",
                   resp_is_write, resp_reg, resp_data, e.w, e.r, e.d);
        end
      end
    end
  end

  task automatic sendReq(input logic w, input logic [4:0] r, input logic [31:0] d);
    int n;
    resp_t e;
    req_valid = 1'b1; req_write = w; req_reg = r; req_data = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_timeout: req_ready=%b, required 1 within 50 cycles", req_ready);
    end else if (w) begin
      if (r != 5'd0) model[r] = d;
`ifdef REGFILE_WRITE_ACK_EN
      e.w = 1'b1; e.r = r; e.d = (r == 5'd0) ? 32'h0 : d;
      expQ.push_back(e);
`endif
    end else begin
      e.w = 1'b0; e.r = r; e.d = (r == 5'd0) ? 32'h0 : model[r];
      expQ.push_back(e);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1; resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b, required 0", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_low: got %b, required 0", resp_valid); end
    ctrl_reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, required 1", req_ready); end
    checks++;
    if ({resp_valid, resp_is_write, resp_reg, resp_data} !== 39'h0) begin
      errors++;
      $display("FAIL idle_resp: got v=%b w=%b reg=%0d data=%h, required all 0",
               resp_valid, resp_is_write, resp_reg, resp_data);
    end
    for (int i = 0; i < 32; i++) sendReq(1'b0, 5'(i), 32'h0);
    waitDrain();
  endtask

  task automatic test_sweep();
    resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sendReq(1'b1, 5'(i), 32'h0000DEAD);
      sendReq(1'b0, 5'(i), 32'h0);
    end
    waitDrain();
  endtask

  task automatic test_back_to_back();
    resp_e_dummy: begin end
    resp_ready = 1'b1;
    sendReq(1'b1, 5'd5, 32'h12345678);
    sendReq(1'b0, 5'd5, 32'h0);
    waitDrain();
    // Sustained reads: req_ready must stay high every cycle while resp_ready is held.
    for (int k = 1; k <= 4; k++) begin
      resp_t e;
      req_valid = 1'b1; req_write = 1'b0; req_reg = 5'(k);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL throughput_ready: read %0d got req_ready=%b, required 1", k, req_ready);
      end else begin
        e.w = 1'b0; e.r = 5'(k); e.d = model[k];
        expQ.push_back(e);
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    waitDrain();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    sendReq(1'b0, 5'd1, 32'h0);
    sendReq(1'b0, 5'd2, 32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_reg = 5'd3;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: cycle %0d got %b, required 0", c, req_ready); end
      checks++;
      if (resp_valid !== 1'b1 || resp_reg !== 5'd1 || resp_data !== model[1]) begin
        errors++;
        $display("FAIL head_stable: cycle %0d got v=%b reg=%0d data=%h, required v=1 reg=1 data=%h",
                 c, resp_valid, resp_reg, resp_data, model[1]);
      end
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    sendReq(1'b0, 5'd3, 32'h0);
    waitDrain();
  endtask

  task automatic test_write_ack();
    resp_ready = 1'b1;
    sendReq(1'b1, 5'd3, 32'hCAFE0001);
    sendReq(1'b1, 5'd0, 32'hFFFFFFFF);
`ifndef REGFILE_WRITE_ACK_EN
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL no_write_ack: got resp_valid=%b, required 0", resp_valid); end
      @(posedge clock); #1;
    end
`endif
    sendReq(1'b0, 5'd3, 32'h0);
    sendReq(1'b0, 5'd0, 32'h0);
    waitDrain();
  endtask

  task automatic test_mid_reset();
    resp_ready = 1'b0;
    sendReq(1'b0, 5'd1, 32'h0);
    sendReq(1'b0, 5'd2, 32'h0);
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL queued_valid: got %b, required 1", resp_valid); end
    #3 ctrl_reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b ready=%b data=%h, required 0 0 0", resp_valid, req_ready, resp_data);
    end
    expQ.delete();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #3 ctrl_reset = 1'b0;
    @(posedge clock); #1;
    resp_ready = 1'b1;
    sendReq(1'b0, 5'd7, 32'h0);
    waitDrain();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_backpressure();
    test_write_ack();
    test_mid_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL leftover: %0d responses outstanding, required 0", expQ.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
